// File: rtl/mem_pkg.sv
// mem_pkg: memop encodings, address map and access helpers shared by the core and dmem_mmio
package mem_pkg;

    typedef enum logic [2:0] {
        MEMOP_B  = 3'b000,
        MEMOP_H  = 3'b001,
        MEMOP_W  = 3'b010,
        MEMOP_BU = 3'b100,
        MEMOP_HU = 3'b101
    } memop_e;

    localparam logic [31:0] RAM_BASE  = 32'h0010_0000;
    localparam logic [31:0] MMIO_BASE = 32'h0020_0000;
    localparam logic [3:0]  LED_OFF   = 4'h0;
    localparam logic [3:0]  TIMER_OFF = 4'h4;
    localparam logic [3:0]  KSTAT_OFF = 4'h8;
    localparam logic [3:0]  KDATA_OFF = 4'hC;

    // Half accesses need addr[0]=0, word accesses need addr[1:0]=0; op[2] only selects extension
    function automatic logic misaligned(input logic [2:0] op, input logic [1:0] a);
        return (op[1:0] == 2'b01 && a[0]) || (op[1:0] == 2'b10 && a != 2'b00);
    endfunction

endpackage

// File: rtl/dmem_mmio_if.sv
// dmem_mmio_if: core-side data memory port (address, store data, op, strobes, load data)
interface dmem_mmio_if;
    logic [31:0] dmemaddr;
    logic [31:0] dmemdatain;
    logic [2:0]  dmemop;
    logic        dmemwe;
    logic        dmemre;
    logic [31:0] dmemdataout;

    modport master (output dmemaddr, dmemdatain, dmemop, dmemwe, dmemre, input dmemdataout);
    modport slave  (input dmemaddr, dmemdatain, dmemop, dmemwe, dmemre, output dmemdataout);
endinterface

// File: rtl/kbd_fifo.sv
// kbd_fifo: scancode FIFO; a pop frees a slot for a same-cycle push, a push into a full FIFO sets sticky overflow
module kbd_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push_i,
    input  logic [7:0] din_i,
    input  logic       pop_i,
    input  logic       clr_ovf_i,
    output logic [7:0] head_o,
    output logic       empty_o,
    output logic       ovf_o
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          full, do_push, do_pop;

    // Pop is evaluated first so a full FIFO can accept a push in the same cycle
    always_comb begin
        full    = cnt_q == (AW+1)'(DEPTH);
        do_pop  = pop_i && cnt_q != '0;
        do_push = push_i && (!full || do_pop);
        wp_d    = do_push ? wp_q + 1'b1 : wp_q;
        rp_d    = do_pop ? rp_q + 1'b1 : rp_q;
        cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        ovf_d   = (clr_ovf_i ? 1'b0 : ovf_q) | (push_i && !do_push);
    end

    // Pointer, count and overflow state
    always_ff @(posedge clock) begin
        if (reset) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    // Entry storage is never reset; only the pointers define validity
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wp_q] <= din_i;
    end

    assign head_o  = mem_q[rp_q];
    assign empty_o = cnt_q == '0;
    assign ovf_o   = ovf_q;
endmodule

// File: rtl/dmem_mmio.sv
// dmem_mmio: data RAM plus LED/timer/keyboard registers behind the core's dmem port, with lane steering
module dmem_mmio
    import mem_pkg::*;
#(
    parameter int RAM_AW     = 15,
    parameter int TICK_DIV   = 50000,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clock,
    input  logic              reset,
    dmem_mmio_if.slave        bus,
    input  logic              kbd_valid,
    input  logic [7:0]        kbd_code,
    output logic [15:0]       led,
    output logic              err_misaligned
);
    localparam logic [29:0] LED_W   = 30'((MMIO_BASE + 32'(LED_OFF)) >> 2);
    localparam logic [29:0] TIMER_W = 30'((MMIO_BASE + 32'(TIMER_OFF)) >> 2);
    localparam logic [29:0] KSTAT_W = 30'((MMIO_BASE + 32'(KSTAT_OFF)) >> 2);
    localparam logic [29:0] KDATA_W = 30'((MMIO_BASE + 32'(KDATA_OFF)) >> 2);

    logic [31:0]       ram_q [2**(RAM_AW-2)];
    logic [RAM_AW-3:0] widx;
    logic [31:0]       word, ram_rd, mmio_rd, rd_d, rd_q, wd, timer_q, timer_d, presc_q, presc_d;
    logic [15:0]       led_q, led_d, half;
    logic [7:0]        byte_v, fifo_head;
    logic [3:0]        be;
    logic [1:0]        a;
    logic              in_ram, sel_led, sel_timer, sel_kstat, sel_kdata, tick, clr_timer;
    logic              fifo_empty, fifo_ovf, err_q;

    // Decode on the aligned-down word address so misaligned accesses hit the containing word
    always_comb begin
        a         = bus.dmemaddr[1:0];
        widx      = bus.dmemaddr[RAM_AW-1:2];
        in_ram    = bus.dmemaddr[31:RAM_AW] == RAM_BASE[31:RAM_AW];
        sel_led   = bus.dmemaddr[31:2] == LED_W;
        sel_timer = bus.dmemaddr[31:2] == TIMER_W;
        sel_kstat = bus.dmemaddr[31:2] == KSTAT_W;
        sel_kdata = bus.dmemaddr[31:2] == KDATA_W;
    end

    // Load path: lane select and extension for RAM, full words for registers, zero elsewhere
    always_comb begin
        word    = ram_q[widx];
        byte_v  = word[{a, 3'b000} +: 8];
        half    = word[{a[1], 4'b0000} +: 16];
        ram_rd  = bus.dmemop == MEMOP_B  ? {{24{byte_v[7]}}, byte_v} :
                  bus.dmemop == MEMOP_BU ? {24'b0, byte_v} :
                  bus.dmemop == MEMOP_H  ? {{16{half[15]}}, half} :
                  bus.dmemop == MEMOP_HU ? {16'b0, half} : word;
        mmio_rd = sel_led   ? {16'b0, led_q} :
                  sel_timer ? timer_q :
                  sel_kstat ? {30'b0, fifo_ovf, !fifo_empty} :
                  sel_kdata ? {24'b0, fifo_empty ? 8'h00 : fifo_head} : 32'h0;
        rd_d    = in_ram ? ram_rd : mmio_rd;
    end

    // Store path: byte enables and store data replicated onto every candidate lane
    always_comb begin
        be = bus.dmemop[1:0] == 2'b00 ? 4'b0001 << a :
             bus.dmemop[1:0] == 2'b01 ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wd = bus.dmemop[1:0] == 2'b00 ? {4{bus.dmemdatain[7:0]}} :
             bus.dmemop[1:0] == 2'b01 ? {2{bus.dmemdatain[15:0]}} : bus.dmemdatain;
    end

    // Timer prescaler and counter; a store to TIMER beats a coincident tick
    always_comb begin
        tick      = presc_q == 32'(TICK_DIV - 1);
        clr_timer = bus.dmemwe && sel_timer;
        presc_d   = (clr_timer || tick) ? 32'h0 : presc_q + 32'h1;
        timer_d   = clr_timer ? 32'h0 : timer_q + 32'(tick);
        led_d     = (bus.dmemwe && sel_led) ? bus.dmemdatain[15:0] : led_q;
    end

    // RAM stores commit at the end of the CPU cycle; reset blocks a pending store
    always_ff @(negedge clock) begin
        if (bus.dmemwe && in_ram && !reset)
            for (int i = 0; i < 4; i++)
                if (be[i]) ram_q[widx][8*i +: 8] <= wd[8*i +: 8];
    end

    // LED and timer live in the store (negedge) domain so stores and ticks share one register
    always_ff @(negedge clock) begin
        if (reset) begin
            led_q   <= '0;
            timer_q <= '0;
            presc_q <= '0;
        end else begin
            led_q   <= led_d;
            timer_q <= timer_d;
            presc_q <= presc_d;
        end
    end

    // Mid-cycle capture of load data and sticky misalignment flag
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            rd_q  <= rd_d;
            err_q <= err_q | ((bus.dmemwe | bus.dmemre) & misaligned(bus.dmemop, a));
        end
    end

    kbd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push_i    (kbd_valid),
        .din_i     (kbd_code),
        .pop_i     (bus.dmemre && sel_kdata),
        .clr_ovf_i (bus.dmemwe && sel_kstat),
        .head_o    (fifo_head),
        .empty_o   (fifo_empty),
        .ovf_o     (fifo_ovf)
    );

    assign bus.dmemdataout = rd_q;
    assign led             = led_q;
    assign err_misaligned  = err_q;
endmodule

// File: tb/tb_dmem_mmio.sv
// tb_dmem_mmio: directed accesses with a scoreboard queue checked by an independent monitor
module tb_dmem_mmio;
    import mem_pkg::*;

    localparam logic [31:0] LED_A = 32'h0020_0000, TIM_A = 32'h0020_0004;
    localparam logic [31:0] KST_A = 32'h0020_0008, KDA_A = 32'h0020_000C, RW_A = 32'h0010_0010;

    typedef struct {
        int          kind;
        logic [31:0] exp;
        string       name;
    } chk_t;

    logic        clock = 1'b0, reset = 1'b1, kbd_valid = 1'b0;
    logic [7:0]  kbd_code = 8'h0;
    logic [15:0] led;
    logic        err_misaligned;
    chk_t        exp_q[$];
    chk_t        c;
    logic [31:0] act;
    int          checks = 0, errors = 0;

    dmem_mmio_if bus();

    dmem_mmio #(.RAM_AW(15), .TICK_DIV(4), .FIFO_DEPTH(16)) dut (
        .clock          (clock),
        .reset          (reset),
        .bus            (bus),
        .kbd_valid      (kbd_valid),
        .kbd_code       (kbd_code),
        .led            (led),
        .err_misaligned (err_misaligned)
    );

    always #5 clock = ~clock;

    // Monitor: one expected entry per CPU cycle, compared after the capture edge
    always @(posedge clock) begin
        #1;
        if (exp_q.size() > 0) begin
            c = exp_q.pop_front();
            act = c.kind == 0 ? bus.dmemdataout : c.kind == 1 ? {16'h0, led} : {31'h0, err_misaligned};
            checks++;
            if (act !== c.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
            end
        end
    end

    task automatic go(input logic we, re, input logic [2:0] op, input logic [31:0] a, d,
                      input logic kv, input logic [7:0] kc);
        @(negedge clock);
        #1;
        bus.dmemwe = we;
        bus.dmemre = re;
        bus.dmemop = op;
        bus.dmemaddr = a;
        bus.dmemdatain = d;
        kbd_valid = kv;
        kbd_code = kc;
    endtask

    task automatic expect_v(input int k, input logic [31:0] e, input string n);
        chk_t t;
        t.kind = k;
        t.exp = e;
        t.name = n;
        exp_q.push_back(t);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) go(0, 0, MEMOP_W, 32'h0, 32'h0, 0, 8'h0);
    endtask

    task automatic st(input logic [2:0] op, input logic [31:0] a, d);
        go(1, 0, op, a, d, 0, 8'h0);
    endtask

    task automatic ld(input logic [2:0] op, input logic [31:0] a, e, input string n);
        go(0, 1, op, a, 32'h0, 0, 8'h0);
        expect_v(0, e, n);
    endtask

    task automatic ld_push(input logic [31:0] a, input logic [7:0] kc, input logic [31:0] e, input string n);
        go(0, 1, MEMOP_W, a, 32'h0, 1, kc);
        expect_v(0, e, n);
    endtask

    task automatic chk(input int k, input logic [31:0] e, input string n);
        go(0, 0, MEMOP_W, 32'h0, 32'h0, 0, 8'h0);
        expect_v(k, e, n);
    endtask

    task automatic push(input logic [7:0] kc);
        go(0, 0, MEMOP_W, 32'h0, 32'h0, 1, kc);
    endtask

    // One-cycle reset; a RAM store issued alongside it must not land
    task automatic do_reset();
        @(negedge clock);
        #1;
        reset = 1'b1;
        bus.dmemwe = 1'b1;
        bus.dmemre = 1'b0;
        bus.dmemop = MEMOP_W;
        bus.dmemaddr = RW_A;
        bus.dmemdatain = 32'hFFFF_FFFF;
        kbd_valid = 1'b0;
        @(negedge clock);
        #1;
        reset = 1'b0;
        bus.dmemwe = 1'b0;
    endtask

    initial begin
        bus.dmemwe = 1'b0;
        bus.dmemre = 1'b0;
        bus.dmemop = MEMOP_W;
        bus.dmemaddr = 32'h0;
        bus.dmemdatain = 32'h0;
        do_reset();
        idle(2);
        ld(MEMOP_W, TIM_A, 32'h0, "timer_k3");
        idle(6);
        ld(MEMOP_W, TIM_A, 32'h2, "timer_k10");
        st(MEMOP_W, TIM_A, 32'h0);
        ld(MEMOP_W, TIM_A, 32'h0, "timer_clear_vs_tick");
        idle(3);
        ld(MEMOP_W, TIM_A, 32'h1, "timer_after_clear");
        chk(2, 32'h0, "err_reset");
        chk(0, 32'h0, "dout_idle");
        st(MEMOP_W, RW_A, 32'hDEAD_BEEF);
        ld(MEMOP_B,  32'h0010_0011, 32'hFFFF_FFBE, "lb");
        ld(MEMOP_BU, 32'h0010_0011, 32'h0000_00BE, "lbu");
        ld(MEMOP_H,  32'h0010_0011, 32'hFFFF_BEEF, "lh_misaligned");
        ld(MEMOP_HU, 32'h0010_0011, 32'h0000_BEEF, "lhu_misaligned");
        chk(2, 32'h1, "err_set");
        st(MEMOP_W, RW_A, 32'h1122_3344);
        st(MEMOP_B, 32'h0010_0013, 32'h0000_0055);
        ld(MEMOP_W, RW_A, 32'h5522_3344, "sb_lane3");
        st(MEMOP_H, RW_A, 32'h0000_AAAA);
        ld(MEMOP_W, RW_A, 32'h5522_AAAA, "sh_low");
        ld(MEMOP_H, 32'h0010_0012, 32'h0000_5522, "lh_high");
        st(MEMOP_W, 32'h0030_0000, 32'h1234_5678);
        ld(MEMOP_W, 32'h0030_0000, 32'h0, "unmapped");
        push(8'h1C);
        push(8'h32);
        ld(MEMOP_W, KST_A, 32'h1, "kstat_nonempty");
        ld(MEMOP_W, KDA_A, 32'h1C, "kdata_0");
        ld(MEMOP_W, KDA_A, 32'h32, "kdata_1");
        ld(MEMOP_W, KDA_A, 32'h0, "kdata_empty");
        ld(MEMOP_W, KST_A, 32'h0, "kstat_empty");
        for (int i = 0; i < 17; i++) push(8'h40 + 8'(i));
        ld(MEMOP_W, KST_A, 32'h3, "kstat_overflow");
        for (int i = 0; i < 16; i++) ld(MEMOP_W, KDA_A, 32'h40 + i, "kdata_order");
        ld(MEMOP_W, KDA_A, 32'h0, "kdata_dropped");
        ld(MEMOP_W, KST_A, 32'h2, "kstat_ovf_sticky");
        st(MEMOP_W, KST_A, 32'h0);
        ld(MEMOP_W, KST_A, 32'h0, "kstat_ovf_clear");
        ld_push(KDA_A, 8'h77, 32'h0, "pushpop_empty");
        ld(MEMOP_W, KDA_A, 32'h77, "pushpop_empty_push");
        for (int i = 0; i < 16; i++) push(8'h60 + 8'(i));
        ld_push(KDA_A, 8'h70, 32'h60, "pushpop_full");
        ld(MEMOP_W, KST_A, 32'h1, "pushpop_full_no_ovf");
        for (int i = 1; i < 17; i++) ld(MEMOP_W, KDA_A, 32'h60 + i, "full_drain");
        ld(MEMOP_W, KST_A, 32'h0, "full_drained");
        st(MEMOP_W, LED_A, 32'h0000_ABCD);
        chk(1, 32'hABCD, "led_write");
        ld(MEMOP_W, LED_A, 32'h0000_ABCD, "led_read");
        do_reset();
        chk(1, 32'h0, "led_reset");
        chk(2, 32'h0, "err_cleared");
        ld(MEMOP_W, RW_A, 32'h5522_AAAA, "ram_retained");
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clock);
        @(negedge clock);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
